// File: rtl/mux_sel_serializer.sv
// -----------------------------------------------------------------------------
// mux_sel_serializer
//   Parallel-in/serial-out stage that owns the select lines of an 8:1 bit mux.
//   A word is captured on a load_valid_i/load_ready_o handshake. The stage then
//   sweeps sel_o through every bit position, holding each one for BIT_DIV
//   clocks, and presents the selected bit on ser_out_o. A one-cycle done_o
//   pulse follows the last bit, and the stage then returns to idle.
//
// Parameters
//   WIDTH      data word width (fixed at 8)
//   SEL_W      select width (log2(WIDTH) = 3)
//   BIT_DIV    clocks each bit is held, 1..255
//   MSB_FIRST  0: sel counts 0->7, 1: sel counts 7->0
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   load_valid_i  upstream has a word on load_data_i
//   load_data_i   word to serialize
//   load_ready_o  stage can accept a word (idle and not in reset)
//   sel_o         select for the downstream 8:1 mux
//   mux_data_o    registered copy of the captured word
//   ser_out_o     mux_data_o[sel_o] while ser_valid_o, else 0
//   ser_valid_o   high for every cycle a bit is presented
//   done_o        one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
module mux_sel_serializer #(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3,
  parameter int BIT_DIV   = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic [SEL_W-1:0] sel_o,
  output logic [WIDTH-1:0] mux_data_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // First and last bit positions of a word depend on the sweep direction.
  localparam logic [SEL_W-1:0] SEL_FIRST = (MSB_FIRST != 0) ? SEL_W'(WIDTH - 1) : SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_LAST  = (MSB_FIRST != 0) ? SEL_W'(0) : SEL_W'(WIDTH - 1);
  localparam logic [7:0]       DIV_LAST  = 8'(BIT_DIV - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [7:0]         div_q, div_d;

  // State, select, word and bit-hold counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      div_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      div_q   <= div_d;
    end
  end

  // Next-state logic for capture, bit sweep and done.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid_i) begin
          data_d  = load_data_i;
          sel_d   = SEL_FIRST;
          div_d   = 8'd0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          // Leave before stepping past the final position so sel never wraps.
          if (sel_q == SEL_LAST) begin
            state_d = ST_DONE;
          end else if (MSB_FIRST != 0) begin
            sel_d = sel_q - SEL_W'(1);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state; ready is masked by reset.
  assign load_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign ser_valid_o  = (state_q == ST_SHIFT);
  assign done_o       = (state_q == ST_DONE);
  assign sel_o        = sel_q;
  assign mux_data_o   = data_q;
  assign ser_out_o    = (state_q == ST_SHIFT) ? data_q[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_serializer
//   Three serializer instances (LSB-first div 1, MSB-first div 1, LSB-first
//   div 3) share one input stream. A cycle-indexed reference model derives
//   every output from the time elapsed since the word was accepted.
// -----------------------------------------------------------------------------
module tb_mux_sel_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;

  logic [2:0] ready_w, valid_w, ser_w, done_w;
  logic [2:0] sel_w   [3];
  logic [7:0] mdata_w [3];

  always #5 clk = ~clk;

  mux_sel_serializer #(.WIDTH(8), .SEL_W(3), .BIT_DIV(1), .MSB_FIRST(0)) u_lsb1 (
    .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_data_i(load_data),
    .load_ready_o(ready_w[0]), .sel_o(sel_w[0]), .mux_data_o(mdata_w[0]),
    .ser_out_o(ser_w[0]), .ser_valid_o(valid_w[0]), .done_o(done_w[0]));

  mux_sel_serializer #(.WIDTH(8), .SEL_W(3), .BIT_DIV(1), .MSB_FIRST(1)) u_msb1 (
    .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_data_i(load_data),
    .load_ready_o(ready_w[1]), .sel_o(sel_w[1]), .mux_data_o(mdata_w[1]),
    .ser_out_o(ser_w[1]), .ser_valid_o(valid_w[1]), .done_o(done_w[1]));

  mux_sel_serializer #(.WIDTH(8), .SEL_W(3), .BIT_DIV(3), .MSB_FIRST(0)) u_lsb3 (
    .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_data_i(load_data),
    .load_ready_o(ready_w[2]), .sel_o(sel_w[2]), .mux_data_o(mdata_w[2]),
    .ser_out_o(ser_w[2]), .ser_valid_o(valid_w[2]), .done_o(done_w[2]));

  int check_cnt = 0;
  int error_cnt = 0;

  // Instance configuration as seen by the model.
  int div_p [3] = '{1, 1, 3};
  int msb_p [3] = '{0, 1, 0};

  // Model: t_m = 0 idle, 1..8*div presenting bits, 8*div+1 done cycle.
  int         t_m    [3];
  logic [7:0] word_m [3];
  logic [2:0] sel_m  [3];
  int         done_m [3];
  int         done_seen [3];

  task automatic check_eq(input string tag, input int inst,
                          input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", tag, inst, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      t_m[i]    = 0;
      word_m[i] = 8'h00;
      sel_m[i]  = 3'd0;
    end
  endtask

  // Advance the model across one rising edge using the inputs held at it.
  task automatic model_edge();
    int k;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (t_m[i] == 0) begin
          if (load_valid) begin
            t_m[i]    = 1;
            word_m[i] = load_data;
          end
        end else if (t_m[i] == 8 * div_p[i] + 1) begin
          t_m[i] = 0;
        end else begin
          t_m[i] = t_m[i] + 1;
        end
        if (t_m[i] >= 1 && t_m[i] <= 8 * div_p[i]) begin
          k = (t_m[i] - 1) / div_p[i];
          sel_m[i] = (msb_p[i] != 0) ? 3'(7 - k) : 3'(k);
        end
        if (t_m[i] == 8 * div_p[i] + 1) done_m[i]++;
      end
    end
  endtask

  task automatic check_all();
    logic ev, eser, edone, erdy;
    for (int i = 0; i < 3; i++) begin
      ev    = (t_m[i] >= 1) && (t_m[i] <= 8 * div_p[i]);
      eser  = ev ? word_m[i][sel_m[i]] : 1'b0;
      edone = (t_m[i] == 8 * div_p[i] + 1);
      erdy  = (t_m[i] == 0) && !rst;
      if (done_w[i] === 1'b1) done_seen[i]++;
      check_eq("load_ready", i, 32'(ready_w[i]), 32'(erdy));
      check_eq("ser_valid",  i, 32'(valid_w[i]), 32'(ev));
      check_eq("sel",        i, 32'(sel_w[i]),   32'(sel_m[i]));
      check_eq("ser_out",    i, 32'(ser_w[i]),   32'(eser));
      check_eq("done",       i, 32'(done_w[i]),  32'(edone));
      check_eq("mux_data",   i, 32'(mdata_w[i]), 32'(word_m[i]));
    end
  endtask

  // Drive inputs, cross one rising edge, then check at the falling edge.
  task automatic step(input logic lv, input logic [7:0] data);
    load_valid = lv;
    load_data  = data;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between edges must clear the outputs without a clock.
  task automatic mid_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step(1'b1, 8'hA5);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      done_m[i]    = 0;
      done_seen[i] = 0;
    end
    model_reset();
    @(negedge clk);
    check_all();
    step(1'b1, 8'h77);
    rst = 1'b0;

    // Single word 0xC4 on every instance, both directions.
    step(1'b1, 8'hC4);
    repeat (27) step(1'b0, 8'h00);

    // Single set bit at the slow rate.
    step(1'b1, 8'h01);
    repeat (27) step(1'b0, 8'h00);

    // Loads while busy are ignored.
    step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b1, 8'h00);
    repeat (26) step(1'b0, 8'h00);

    // Abort after three bits, then a clean word from sel start.
    step(1'b1, 8'hAA);
    repeat (2) step(1'b0, 8'h00);
    mid_reset();
    step(1'b1, 8'h55);
    repeat (27) step(1'b0, 8'h00);

    // Continuous valid: back-to-back words with one idle cycle between.
    step(1'b1, 8'h3C);
    repeat (60) step(1'b1, 8'hC3);
    repeat (27) step(1'b0, 8'h00);

    // Randomized traffic with occasional asynchronous resets.
    repeat (500) begin
      if ($urandom_range(0, 79) == 0) mid_reset();
      step($urandom_range(0, 2) == 0, 8'($urandom));
    end
    repeat (27) step(1'b0, 8'h00);

    for (int i = 0; i < 3; i++) check_eq("done_count", i, 32'(done_seen[i]), 32'(done_m[i]));

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
